approx_mul_iter: RTL



---
 rtl/approx_mul_iter_if.sv | 27 ++
 rtl/approx_mul_iter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/approx_mul_iter_if.sv
// approx_mul_iter_if: operand/result handshake bundle for approx_mul_iter.
// The master drives operands and accepts results; the slave is the multiplier.
interface approx_mul_iter_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 approx;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod;
    logic                 busy;
    logic                 err_flag;
    logic [7:0]           err_cnt;

    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, prod, busy, err_flag, err_cnt
    );

    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, prod, busy, err_flag, err_cnt
    );
endinterface

// File: rtl/approx_mul_iter.sv
// approx_mul_iter: iterative shift-add multiplier with a run-time column-truncated approximate mode.
// Define ERR_MON_EN to compile in the exact-product error monitor (err_flag / err_cnt).
module approx_mul_iter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TRUNC = 2,
    parameter int unsigned ET    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    approx_mul_iter_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    // Clears product columns [TRUNC-1:0]; TRUNC=0 yields all ones, TRUNC=PW yields zero.
    localparam logic [PW-1:0] TMASK = ~((PW'(1) << TRUNC) - PW'(1));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_last;

    logic [PW-1:0]   r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic            r_approx;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_step;
    logic [PW-1:0]   r_prod;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [PW-1:0]   w_pp_raw;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_sum;

    // Current partial product: multiplicand is pre-shifted, multiplier bit 0 selects it.
    assign w_pp_raw = r_mplier[0] ? r_mcand : '0;
    assign w_pp     = r_approx ? (w_pp_raw & TMASK) : w_pp_raw;
    assign w_sum    = r_acc + w_pp;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_step == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State plus handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_approx <= 1'b0;
            r_acc    <= '0;
            r_step   <= '0;
            r_prod   <= '0;
        end else if (w_accept) begin
            r_mcand  <= PW'(bus.a);
            r_mplier <= bus.b;
            r_approx <= bus.approx;
            r_acc    <= '0;
            r_step   <= '0;
        end else if (r_state == S_RUN) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_sum;
            r_step   <= r_step + CW'(1);
            if (w_last) begin
                r_prod <= w_sum;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.prod      = r_prod;

`ifdef ERR_MON_EN
    logic [PW-1:0] r_exact;
    logic          r_err_flag;
    logic [7:0]    r_err_cnt;
    logic [PW-1:0] w_diff;
    logic          w_err;

    assign w_diff = (r_exact >= w_sum) ? (r_exact - w_sum) : (w_sum - r_exact);
    assign w_err  = 32'(w_diff) > ET;

    // Exact reference captured at accept; verdict and saturating count updated on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exact    <= '0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_exact <= PW'(bus.a) * PW'(bus.b);
            end
            if (w_last) begin
                r_err_flag <= w_err;
                if (w_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.err_flag = r_err_flag;
    assign bus.err_cnt  = r_err_cnt;
`else
    assign bus.err_flag = 1'b0;
    assign bus.err_cnt  = 8'd0;
`endif

endmodule
